// File: rtl/mem_writer.sv
// Burst write controller for the 8x16 register-file memory: valid/ready stream in, registered write port out.
// Optional MEM_WRITER_CSUM_EN adds a running XOR checksum output of the words accepted in the current burst.
module mem_writer #(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] din,
  output logic          busy,
  output logic          done
`ifdef MEM_WRITER_CSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] din_q, din_d;
  logic          beat_s;
`ifdef MEM_WRITER_CSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  // s_ready is a pure state decode so it never depends on s_valid
  assign s_ready = (state_q == WRITE);
  assign busy    = (state_q == WRITE);
  assign done    = (state_q == DONE);
  assign beat_s  = s_valid && s_ready;
  assign we      = we_q;
  assign waddr   = waddr_q;
  assign din     = din_q;
`ifdef MEM_WRITER_CSUM_EN
  assign csum    = csum_q;
`endif

  // Next-state and write-port computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
`ifdef MEM_WRITER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MEM_WRITER_CSUM_EN
          csum_d = {DW{1'b0}};
`endif
          if (len != {LW{1'b0}}) begin
            ptr_d   = base;
            rem_d   = len;
            state_d = WRITE;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (beat_s) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          din_d   = s_data;
          ptr_d   = ptr_q + {{(AW-1){1'b0}}, 1'b1};
          rem_d   = rem_q - {{(LW-1){1'b0}}, 1'b1};
`ifdef MEM_WRITER_CSUM_EN
          csum_d  = csum_q ^ s_data;
`endif
          if (rem_q == {{(LW-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered write port, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= {AW{1'b0}};
      rem_q   <= {LW{1'b0}};
      we_q    <= 1'b0;
      waddr_q <= {AW{1'b0}};
      din_q   <= {DW{1'b0}};
`ifdef MEM_WRITER_CSUM_EN
      csum_q  <= {DW{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
`ifdef MEM_WRITER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
